stack_ctrl: RTL and testbench
=============================

// Module: stack_ctrl
// PURPOSE
//   Push-down stack controller sequencing the 1024x8 single-port RAM (shared bidirectional
//   data bus, active-high WEn/CS). Accepts push/pop requests, keeps the stack pointer,
//   generates RAM address/WEn/CS with setup and hold phases, and owns bus turnaround.
//   Sits between the stack's user logic and the RAM instance.
// PARAMETERS
//   DATA_W  8     data width, equal to the RAM word width
//   ADDR_W  10    RAM address width; DEPTH = 2**ADDR_W = 1024 entries
// PORTS
//   clk_i       in     1         clock; all state updates on rising edge
//   rst_i       in     1         synchronous reset, active-high
//   push_i      in     1         push request; sampled in IDLE only
//   pop_i       in     1         pop request; sampled in IDLE only
//   data_i      in     DATA_W    push data; captured on push accept
//   data_o      out    DATA_W    last popped word; held until next pop completes
//   valid_o     out    1         1-cycle pulse: data_o updated by a pop
//   busy_o      out    1         high in every state except IDLE
//   full_o      out    1         count_o == DEPTH
//   empty_o     out    1         count_o == 0
//   ovf_o       out    1         1-cycle pulse: push rejected (full)
//   udf_o       out    1         1-cycle pulse: pop rejected (empty)
//   count_o     out    ADDR_W+1  number of stored entries, 0..DEPTH
//   ram_addr_o  out    ADDR_W    RAM address
//   ram_wen_o   out    1         RAM write enable
//   ram_cs_o    out    1         RAM chip select
//   ram_data_io inout  DATA_W    RAM data bus; driven only in WR_* states, else Z
// BEHAVIOUR
//   Reset: state=IDLE, sp=0, count_o=0, data_o=0, valid_o/ovf_o/udf_o=0, ram_cs_o=0,
//     ram_wen_o=0, ram_addr_o=0, ram_data_io=Z, empty_o=1, full_o=0. Reset mid-operation
//     aborts at the next edge: in-flight push not counted, in-flight pop gives no valid_o.
//   sp = count_o; next write address = sp, top of stack = sp-1 (ADDR_W bits).
//   ram_* outputs are decoded from registered state/address/data regs only.
//   FSM (one cycle per state):
//     IDLE     cs=0 wen=0 bus Z. push_i&!full: latch data_i, addr<=sp -> WR_SETUP.
//              push_i&full: ovf_o pulse, stay. Else pop_i&!empty: addr<=sp-1 -> RD_ADDR.
//              pop_i&empty: udf_o pulse, stay. push_i&pop_i: push wins, pop dropped silently.
//     WR_SETUP cs=0 wen=0, addr and data driven -> WR_PULSE
//     WR_PULSE cs=1 wen=1, addr and data driven -> WR_HOLD
//     WR_HOLD  cs=0 wen=0, addr and data still driven; count_o<=count_o+1 at exit -> IDLE
//     RD_ADDR  cs=0 wen=0, addr driven, bus Z -> RD_DATA
//     RD_DATA  cs=1 wen=0, bus Z; at exit data_o<=ram_data_io, count_o<=count_o-1,
//              valid_o=1 in the following IDLE cycle -> IDLE
//   Latency: push 3 busy cycles; pop 2 busy cycles, valid_o in 3rd cycle after accept.
//   Requests while busy_o=1 are ignored (no flags). Back-to-back ops need 1 IDLE cycle,
//     which also guarantees bus turnaround between controller drive and RAM drive.
//   Invariant: controller drives bus only when !(ram_cs_o & !ram_wen_o); never both drive.
//   count_o saturates by construction: no push at DEPTH, no pop at 0; sp never wraps.
//   full_o/empty_o combinational from count_o.
// TESTING
//   1 Reset -> empty_o=1, full_o=0, count_o=0, ram_cs_o=0, ram_data_io=Z, data_o=0.
//   2 Push 0xA5, push 0x3C, pop, pop -> data_o 0x3C then 0xA5 with one valid_o each,
//     RAM addr 0,1 written then 1,0 read, count 0->2->0, empty_o=1 at end.
//   3 1024 pushes (data=i[7:0]) -> full_o=1, count_o=1024; 1025th push -> ovf_o pulse,
//     no cs activity, count unchanged; pop -> data_o=0xFF, count_o=1023.
//   4 Pop on empty -> udf_o pulse 1 cycle, ram_cs_o stays 0, valid_o stays 0.
//   5 count_o=1, push_i=pop_i=1 (data 0x77) in IDLE -> push only, count_o=2, no udf_o;
//     next pop -> 0x77.
//   6 rst_i during WR_PULSE -> next cycle IDLE, cs=0, bus Z, count_o=0; rst_i during
//     RD_DATA -> no valid_o, data_o=0. Monitor bus-contention invariant throughout.

Source files
------------

// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
// stack_ctrl : push-down stack controller for a 1024x8 single-port RAM with a
//              shared bidirectional data bus and active-high WEn/CS strobes.
// Revision   : 1.0
// ============================================================================
module stack_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              ovf_o,
  output logic              udf_o,
  output logic [ADDR_W:0]   count_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wen_o,
  output logic              ram_cs_o,
  inout  wire  [DATA_W-1:0] ram_data_io
);

  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_SETUP = 3'd1,
    WR_PULSE = 3'd2,
    WR_HOLD  = 3'd3,
    RD_ADDR  = 3'd4,
    RD_DATA  = 3'd5
  } state_t;

  state_t              state_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                valid_q;
  logic                ovf_q;
  logic                udf_q;

  logic                w_full;
  logic                w_empty;
  logic                w_drive;

  assign w_full  = (count_q == FULL_CNT);
  assign w_empty = (count_q == '0);

  // The stack pointer equals the entry count, so it can never wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (push_i) begin
            if (w_full) begin
              ovf_q <= 1'b1;
            end else begin
              wdata_q <= data_i;
              addr_q  <= count_q[ADDR_W-1:0];
              state_q <= WR_SETUP;
            end
          end else if (pop_i) begin
            if (w_empty) begin
              udf_q <= 1'b1;
            end else begin
              addr_q  <= count_q[ADDR_W-1:0] - ONE_ADDR;
              state_q <= RD_ADDR;
            end
          end
        end
        WR_SETUP: state_q <= WR_PULSE;
        WR_PULSE: state_q <= WR_HOLD;
        WR_HOLD: begin
          count_q <= count_q + ONE_CNT;
          state_q <= IDLE;
        end
        RD_ADDR: state_q <= RD_DATA;
        RD_DATA: begin
          rdata_q <= ram_data_io;
          count_q <= count_q - ONE_CNT;
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus is released outside the write phases; RD_ADDR gives a turnaround cycle.
  assign w_drive     = (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_HOLD);
  assign ram_data_io = w_drive ? wdata_q : {DATA_W{1'bz}};
  assign ram_cs_o    = (state_q == WR_PULSE) || (state_q == RD_DATA);
  assign ram_wen_o   = (state_q == WR_PULSE);
  assign ram_addr_o  = addr_q;

  assign data_o  = rdata_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;
  assign busy_o  = (state_q != IDLE);
  assign count_o = count_q;
  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// ============================================================================
// tb_stack_ctrl : scoreboard bench for stack_ctrl with a RAM model on the bus.
// Revision      : 1.0
// ============================================================================
module tb_stack_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic          pop;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          valid, busy, full, empty, ovf, udf;
  logic [AW:0]   count;
  logic [AW-1:0] addr;
  logic          wen, cs;
  wire  [DW-1:0] bus;

  logic [DW-1:0] mem [DEPTH];

  stack_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .push_i(push), .pop_i(pop), .data_i(din),
    .data_o(dout), .valid_o(valid), .busy_o(busy), .full_o(full), .empty_o(empty),
    .ovf_o(ovf), .udf_o(udf), .count_o(count), .ram_addr_o(addr),
    .ram_wen_o(wen), .ram_cs_o(cs), .ram_data_io(bus)
  );

  always #5 clk = ~clk;

  // RAM model: drives the bus only on a read strobe, writes on a write strobe.
  assign bus = (cs && !wen) ? mem[addr] : {DW{1'bz}};
  always @(posedge clk) if (cs && wen) mem[addr] <= bus;

  typedef struct packed { logic [1:0] kind; logic [DW-1:0] data; } ev_t;
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ba_t;

  ev_t           evq[$];
  ba_t           wq[$];
  ba_t           rq[$];
  logic [DW-1:0] stk[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT shows an event or bus strobe.
  ev_t mon_e;
  ba_t mon_b;
  int  mon_k;
  always @(negedge clk) begin
    if (valid || ovf || udf) begin
      mon_k = valid ? 0 : (ovf ? 1 : 2);
      chk("event_expected", int'(evq.size() != 0), 1);
      if (evq.size() != 0) begin
        mon_e = evq.pop_front();
        chk("event_kind", mon_k, int'(mon_e.kind));
        chk("event_onehot", int'(valid) + int'(ovf) + int'(udf), 1);
        if (valid) chk("data_o", int'(dout), int'(mon_e.data));
      end
    end
    if (cs && wen) begin
      chk("write_expected", int'(wq.size() != 0), 1);
      if (wq.size() != 0) begin
        mon_b = wq.pop_front();
        chk("write_addr", int'(addr), int'(mon_b.a));
        chk("write_data", int'(bus), int'(mon_b.d));
      end
    end
    if (cs && !wen) begin
      chk("read_expected", int'(rq.size() != 0), 1);
      if (rq.size() != 0) begin
        mon_b = rq.pop_front();
        chk("read_addr", int'(addr), int'(mon_b.a));
        chk("read_bus", int'(bus), int'(mon_b.d));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  task automatic check_count(input string nm);
    chk({nm, "_count"}, int'(count), stk.size());
    chk({nm, "_empty"}, int'(empty), int'(stk.size() == 0));
    chk({nm, "_full"},  int'(full),  int'(stk.size() == DEPTH));
  endtask

  // Stack rules: push wins over pop; full push -> ovf, empty pop -> udf.
  task automatic issue(input bit p, input bit q, input logic [DW-1:0] d);
    int n;
    wait_idle();
    n = stk.size();
    if (p) begin
      if (n == DEPTH) evq.push_back('{kind: 2'd1, data: '0});
      else begin
        wq.push_back('{a: AW'(n), d: d});
        stk.push_back(d);
      end
    end else if (q) begin
      if (n == 0) evq.push_back('{kind: 2'd2, data: '0});
      else begin
        rq.push_back('{a: AW'(n - 1), d: stk[$]});
        evq.push_back('{kind: 2'd0, data: stk[$]});
        void'(stk.pop_back());
      end
    end
    push = p; pop = q; din = d;
    @(posedge clk);
    #1 push = 1'b0; pop = 1'b0; din = DW'($urandom);
    wait_idle();
    @(negedge clk);
    check_count("op");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stk.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    push = 1'b0; pop = 1'b0; din = '0; rst = 1'b1;
    do_reset();
    @(negedge clk);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_cs",    int'(cs), 0);
    chk("rst_wen",   int'(wen), 0);
    chk("rst_addr",  int'(addr), 0);
    chk("rst_data",  int'(dout), 0);
    chk("rst_busy",  int'(busy), 0);

    // Basic LIFO order.
    issue(1, 0, 8'hA5);
    issue(1, 0, 8'h3C);
    chk("two_count", int'(count), 2);
    issue(0, 1, 8'h00);
    issue(0, 1, 8'h00);
    chk("basic_empty", int'(empty), 1);

    // Fill to capacity, overflow, then pop the last word.
    for (int i = 0; i < DEPTH; i++) issue(1, 0, DW'(i));
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), DEPTH);
    issue(1, 0, 8'h5A);
    issue(0, 1, 8'h00);
    chk("after_pop_data", int'(dout), 8'hFF);
    chk("after_pop_count", int'(count), DEPTH - 1);

    // Underflow.
    do_reset();
    issue(0, 1, 8'h00);
    chk("udf_data_kept", int'(dout), 0);

    // Simultaneous push and pop: push wins.
    issue(1, 0, 8'h11);
    issue(1, 1, 8'h77);
    chk("both_count", int'(count), 2);
    issue(0, 1, 8'h00);
    chk("both_pop", int'(dout), 8'h77);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      issue(r < 5 || r == 9, r >= 5, DW'($urandom));
    end

    // Reset while the write strobe is active.
    wait_idle();
    wq.push_back('{a: AW'(stk.size()), d: 8'hC3});
    push = 1'b1; din = 8'hC3;
    @(posedge clk);
    #1 push = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("wr_rst_busy", int'(busy), 0);
    chk("wr_rst_cs", int'(cs), 0);
    chk("wr_rst_count", int'(count), 0);
    rst = 1'b0;
    stk.delete();
    chk("wr_rst_strobe_seen", wq.size(), 0);

    // Reset while the read strobe is active.
    issue(1, 0, 8'h9E);
    wait_idle();
    rq.push_back('{a: AW'(0), d: 8'h9E});
    pop = 1'b1;
    @(posedge clk);
    #1 pop = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    stk.delete();
    repeat (4) @(negedge clk);
    chk("rd_rst_valid", int'(valid), 0);
    chk("rd_rst_data", int'(dout), 0);
    chk("rd_rst_count", int'(count), 0);
    chk("rd_rst_strobe_seen", rq.size(), 0);

    chk("events_drained", evq.size(), 0);
    chk("writes_drained", wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
